// File: rtl/bus_arb_seq_if.sv
// Arbiter bus bundle: two master requests, muxed strobe/ready in, grants and status out.
// Latency: none (wires only).
// Backpressure: none here; ready_i from the slave mux stalls the owning master.
`timescale 1ns/1ps
interface bus_arb_seq_if;
    logic req_m0;
    logic req_m1;
    logic addr_strobe_i;
    logic ready_i;
    logic grant_m0;
    logic grant_m1;
    logic owner_o;
    logic busy_o;
    logic timeout_o;

    // Requesting/bus side: drives requests and the muxed strobe/ready.
    modport master (
        output req_m0, req_m1, addr_strobe_i, ready_i,
        input  grant_m0, grant_m1, owner_o, busy_o, timeout_o
    );

    // Arbiter side.
    modport slave (
        input  req_m0, req_m1, addr_strobe_i, ready_i,
        output grant_m0, grant_m1, owner_o, busy_o, timeout_o
    );
endinterface

// File: rtl/bus_arb_seq.sv
// Two-master round-robin bus arbiter with bus parking and optional stall timeout (BUS_TIMEOUT_EN).
// Latency: grant one cycle after request seen in IDLE; all outputs registered.
// Backpressure: ready_i low holds WAIT (grant kept) until ready or, with BUS_TIMEOUT_EN, abort.
`timescale 1ns/1ps
module bus_arb_seq #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    bus_arb_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state_q;
    logic   grant_m0_q;
    logic   grant_m1_q;
    logic   last_owner_q;
    logic   busy_q;
    logic   timeout_q;
    // Low for the first edge after reset release so no grant lands on that edge.
    logic   armed_q;

    logic   owner_req;
    logic   other_req;
    logic   park;
    logic   pick;

    assign owner_req = last_owner_q ? bus.req_m1 : bus.req_m0;
    assign other_req = last_owner_q ? bus.req_m0 : bus.req_m1;
    // On completion: stay on the bus only if the owner still wants it and nobody else does.
    assign park      = owner_req & ~other_req;
    // Contested: the master that did not own last; otherwise the lone requester.
    assign pick      = (bus.req_m0 & bus.req_m1) ? ~last_owner_q : bus.req_m1;

`ifdef BUS_TIMEOUT_EN
    logic [7:0] cnt_q;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
`else
    logic [7:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
`endif

    // Arbitration FSM with registered grants, owner, busy and timeout pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_m0_q   <= 1'b0;
            grant_m1_q   <= 1'b0;
            last_owner_q <= 1'b1;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            armed_q      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_q        <= 8'd0;
`endif
        end else begin
            timeout_q <= 1'b0;
            armed_q   <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (armed_q && (bus.req_m0 || bus.req_m1)) begin
                        state_q      <= OWN;
                        busy_q       <= 1'b1;
                        last_owner_q <= pick;
                        grant_m0_q   <= ~pick;
                        grant_m1_q   <= pick;
                    end
                end
                OWN: begin
                    if (bus.addr_strobe_i) begin
                        if (bus.ready_i) begin
                            // Zero-wait slave: complete without visiting WAIT.
                            if (!park) begin
                                state_q    <= IDLE;
                                busy_q     <= 1'b0;
                                grant_m0_q <= 1'b0;
                                grant_m1_q <= 1'b0;
                            end
                        end else begin
                            state_q <= WAIT;
`ifdef BUS_TIMEOUT_EN
                            cnt_q   <= 8'd0;
`endif
                        end
                    end else if (!owner_req) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        grant_m0_q <= 1'b0;
                        grant_m1_q <= 1'b0;
                    end
                end
                WAIT: begin
                    // ready_i takes priority over a timeout firing on the same edge.
                    if (bus.ready_i) begin
`ifdef BUS_TIMEOUT_EN
                        cnt_q <= 8'd0;
`endif
                        if (park) begin
                            state_q <= OWN;
                        end else begin
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                            grant_m0_q <= 1'b0;
                            grant_m1_q <= 1'b0;
                        end
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        grant_m0_q <= 1'b0;
                        grant_m1_q <= 1'b0;
                        timeout_q  <= 1'b1;
                        cnt_q      <= 8'd0;
                    end else if (cnt_q != 8'hFF) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`endif
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    grant_m0_q <= 1'b0;
                    grant_m1_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
                    cnt_q      <= 8'd0;
`endif
                end
            endcase
        end
    end

    assign bus.grant_m0  = grant_m0_q;
    assign bus.grant_m1  = grant_m1_q;
    assign bus.owner_o   = last_owner_q;
    assign bus.busy_o    = busy_q;
    assign bus.timeout_o = timeout_q;

endmodule
